// File: rtl/alu_input_sequencer_if.sv
// Signal bundle between the operand sequencer and the board/ALU side.
// master: the sequencer (consumes switches, button and ALU result; drives ALU inputs).
// slave:  the board/ALU side (drives switches, button and ALU result).
interface alu_input_sequencer_if;
    logic [3:0] data_in;
    logic       load_btn;
    logic [3:0] alu_result;
    logic [3:0] alu_in_1;
    logic [3:0] alu_in_2;
    logic [3:0] alu_op;
    logic [3:0] result_q;
    logic       result_valid;
    logic [2:0] state_o;

    modport master (
        input  data_in, load_btn, alu_result,
        output alu_in_1, alu_in_2, alu_op, result_q, result_valid, state_o
    );

    modport slave (
        output data_in, load_btn, alu_result,
        input  alu_in_1, alu_in_2, alu_op, result_q, result_valid, state_o
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// Push-button driven operand sequencer for a 4-bit ALU: one debounced press
// each loads operand A, operand B and the opcode, then the ALU result is
// captured and shown until the next press starts a new operand set.
//
// Handshake: there is no ready/backpressure. result_valid is a level
// qualifier that is high exactly while the FSM sits in SHOW, i.e. while
// result_q belongs to the operand set currently on alu_in_1/alu_in_2/alu_op.
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    alu_input_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic       db_level;
    logic       db_prev;
    logic [7:0] db_cnt;
    logic       press_evt;
    logic       press_go;

    state_t     state_q;
    state_t     state_d;
    logic       cap_a;
    logic       cap_b;
    logic       cap_op;
    logic       cap_res;
    logic       clr_valid;

    logic [3:0] alu_in_1_q;
    logic [3:0] alu_in_2_q;
    logic [3:0] alu_op_q;
    logic [3:0] result_q_q;
    logic       result_valid_q;

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= bus.load_btn;
            sync_2 <= sync_1;
        end
    end

    // Debounce: accept the synchronized level once it has differed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= 8'd0;
            db_prev  <= 1'b0;
        end else begin
            db_prev <= db_level;
            if (sync_2 != db_level) begin
                if (db_cnt == CNT_MAX) begin
                    db_level <= sync_2;
                    db_cnt   <= 8'd0;
                end else begin
                    db_cnt <= db_cnt + 8'd1;
                end
            end else begin
                db_cnt <= 8'd0;
            end
        end
    end

    // Rising edge of the debounced level only; release is silent. ena gates consumption.
    assign press_evt = db_level & ~db_prev;
    assign press_go  = press_evt & ena;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and capture strobes; illegal encodings recover to LOAD_A regardless of ena.
    always_comb begin
        state_d   = state_q;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        cap_op    = 1'b0;
        cap_res   = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (press_go) begin
                    cap_a   = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press_go) begin
                    cap_b   = 1'b1;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (press_go) begin
                    cap_op  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ena) begin
                    cap_res = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press_go) begin
                    clr_valid = 1'b1;
                    state_d   = LOAD_A;
                end
            end
            default: begin
                clr_valid = 1'b1;
                state_d   = LOAD_A;
            end
        endcase
    end

    // Operand, opcode and result capture registers; values persist until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in_1_q     <= 4'd0;
            alu_in_2_q     <= 4'd0;
            alu_op_q       <= 4'd0;
            result_q_q     <= 4'd0;
            result_valid_q <= 1'b0;
        end else begin
            if (cap_a) begin
                alu_in_1_q <= bus.data_in;
            end
            if (cap_b) begin
                alu_in_2_q <= bus.data_in;
            end
            if (cap_op) begin
                alu_op_q <= bus.data_in;
            end
            if (cap_res) begin
                result_q_q     <= bus.alu_result;
                result_valid_q <= 1'b1;
            end else if (clr_valid) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_in_1     = alu_in_1_q;
    assign bus.alu_in_2     = alu_in_2_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.result_q     = result_q_q;
    assign bus.result_valid = result_valid_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer with DEBOUNCE_CYCLES=4 and a small ALU
// modelled here. A behavioural model tracks what the sequencer must show
// each cycle; directed scenarios add literal expectations on top.
module tb_alu_input_sequencer;

    localparam int DB = 4;

    logic clk;
    logic rst_n;
    logic ena;

    int total;
    int bad;
    int trans_cnt;
    logic [2:0] prev_state;

    alu_input_sequencer_if bus ();

    alu_input_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return 4'(a + b);
            4'd1:    return 4'(a - b);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 4'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_in_1, bus.alu_in_2, bus.alu_op);

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw button seen through a two-sample delay; a new level is accepted
    // after it has been seen DB times in a row; an acceptance of "pressed"
    // is consumed on the following edge (if ena).
    logic [1:0] m_pipe   = 2'b00;
    logic       m_deb    = 1'b0;
    logic       m_deb_d  = 1'b0;
    int         m_run    = 0;
    int         m_step   = 0;   // 0 A, 1 B, 2 OP, 3 EXEC, 4 SHOW
    logic [3:0] m_a      = 4'd0;
    logic [3:0] m_b      = 4'd0;
    logic [3:0] m_op     = 4'd0;
    logic [3:0] m_res    = 4'd0;
    logic       m_valid  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe  = 2'b00;
            m_deb   = 1'b0;
            m_deb_d = 1'b0;
            m_run   = 0;
            m_step  = 0;
            m_a     = 4'd0;
            m_b     = 4'd0;
            m_op    = 4'd0;
            m_res   = 4'd0;
            m_valid = 1'b0;
        end else begin
            if (ena) begin
                if (m_step == 3) begin
                    m_res   = alu_fn(m_a, m_b, m_op);
                    m_valid = 1'b1;
                    m_step  = 4;
                end else if (m_deb && !m_deb_d) begin
                    case (m_step)
                        0: m_a  = bus.data_in;
                        1: m_b  = bus.data_in;
                        2: m_op = bus.data_in;
                        default: m_valid = 1'b0;
                    endcase
                    m_step = (m_step + 1) % 5;
                    if (m_step == 4) m_step = 0;
                    if (m_step == 3) m_step = 3;
                end
            end
            m_deb_d = m_deb;
            if (m_pipe[1] != m_deb) begin
                m_run++;
                if (m_run == DB) begin
                    m_deb = m_pipe[1];
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_pipe = {m_pipe[0], bus.load_btn};
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("seq_alu_in_1", 8'(bus.alu_in_1), 8'(m_a));
        check("seq_alu_in_2", 8'(bus.alu_in_2), 8'(m_b));
        check("seq_alu_op", 8'(bus.alu_op), 8'(m_op));
        check("seq_result_q", 8'(bus.result_q), 8'(m_res));
        check("seq_result_valid", 8'(bus.result_valid), 8'(m_valid));
        check("seq_state", 8'(bus.state_o), 8'(m_step));
    end

    // Transition monitor.
    initial begin
        trans_cnt  = 0;
        prev_state = 3'd0;
    end
    always @(negedge clk) begin
        if (bus.state_o != prev_state) trans_cnt++;
        prev_state = bus.state_o;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] v);
        bus.data_in  = v;
        bus.load_btn = 1'b1;
        tick(10);
        bus.load_btn = 1'b0;
        tick(10);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        bit found;
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.data_in  = 4'd0;
        bus.load_btn = 1'b0;
        tick(3);
        check("reset_state", 8'(bus.state_o), 8'd0);
        check("reset_a", 8'(bus.alu_in_1), 8'd0);
        check("reset_valid", 8'(bus.result_valid), 8'd0);
        rst_n = 1'b1;
        tick(2);

        // ADD 3 + 4
        press(4'd3);
        check("add_state_b", 8'(bus.state_o), 8'd1);
        press(4'd4);
        press(4'd0);
        check("add_a", 8'(bus.alu_in_1), 8'd3);
        check("add_b", 8'(bus.alu_in_2), 8'd4);
        check("add_op", 8'(bus.alu_op), 8'd0);
        check("add_res", 8'(bus.result_q), 8'd7);
        check("add_model_res", 8'(m_res), 8'd7);
        check("add_valid", 8'(bus.result_valid), 8'd1);
        check("add_state", 8'(bus.state_o), 8'd4);
        press(4'd0);
        check("show_exit_state", 8'(bus.state_o), 8'd0);
        check("show_exit_valid", 8'(bus.result_valid), 8'd0);
        check("show_exit_keep_res", 8'(bus.result_q), 8'd7);

        // Wrap F + 1
        press(4'hF);
        press(4'h1);
        press(4'h0);
        check("wrap_res", 8'(bus.result_q), 8'd0);
        check("wrap_valid", 8'(bus.result_valid), 8'd1);
        press(4'd0);

        // Bounce shorter than debounce window
        t0 = trans_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.load_btn = ~bus.load_btn;
            tick(2);
        end
        bus.load_btn = 1'b0;
        tick(10);
        check("bounce_transitions", 8'(trans_cnt - t0), 8'd0);
        check("bounce_state", 8'(bus.state_o), 8'd0);

        // Reset while in EXEC
        press(4'd6);
        press(4'd7);
        bus.data_in  = 4'd1;
        bus.load_btn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.state_o == 3'd3) found = 1'b1;
        end
        check("wait_exec", 8'(found), 8'd1);
        #2;
        rst_n        = 1'b0;
        bus.load_btn = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("exec_rst_state", 8'(bus.state_o), 8'd0);
        check("exec_rst_valid", 8'(bus.result_valid), 8'd0);
        check("exec_rst_a", 8'(bus.alu_in_1), 8'd0);
        check("exec_rst_b", 8'(bus.alu_in_2), 8'd0);
        check("exec_rst_op", 8'(bus.alu_op), 8'd0);
        check("exec_rst_res", 8'(bus.result_q), 8'd0);
        press(4'hA);
        check("post_rst_a", 8'(bus.alu_in_1), 8'hA);
        check("post_rst_state", 8'(bus.state_o), 8'd1);

        // ena low discards a press in LOAD_B
        ena = 1'b0;
        press(4'd5);
        check("ena_hold_state", 8'(bus.state_o), 8'd1);
        check("ena_hold_b", 8'(bus.alu_in_2), 8'd0);
        ena = 1'b1;
        press(4'd9);
        check("ena_resume_state", 8'(bus.state_o), 8'd2);
        check("ena_resume_b", 8'(bus.alu_in_2), 8'd9);
        press(4'd2);
        check("and_res", 8'(bus.result_q), 8'd8);
        press(4'd0);

        // Long hold: exactly one event
        t0 = trans_cnt;
        bus.data_in  = 4'hC;
        bus.load_btn = 1'b1;
        tick(200);
        check("hold_transitions", 8'(trans_cnt - t0), 8'd1);
        check("hold_state", 8'(bus.state_o), 8'd1);
        check("hold_a", 8'(bus.alu_in_1), 8'hC);
        bus.load_btn = 1'b0;
        tick(10);

        // Randomized presses, glitches, ena gaps and resets
        for (int i = 0; i < 60; i++) begin
            bus.data_in = 4'($urandom_range(0, 15));
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
                    bus.load_btn = ~bus.load_btn;
                    tick($urandom_range(1, 3));
                end
            end
            bus.load_btn = 1'b1;
            tick($urandom_range(1, 12));
            bus.load_btn = 1'b0;
            tick($urandom_range(1, 12));
        end
        ena = 1'b1;
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
